// File: rtl/sprite_fetch_arbiter_pkg.sv
// rtl/sprite_fetch_arbiter_pkg.sv - shared types, constants and pattern-offset helper
package sprite_fetch_arbiter_pkg;

  localparam int                 VRAM_AW              = 13;
  localparam logic [VRAM_AW-1:0] SPR_TILE_BASE        = 13'h0000;
  localparam int                 MAX_SPRITES_PER_LINE = 10;
  localparam int                 DEF_READ_CYCLES      = 2;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_BG,
    LO_RD,
    HI_RD,
    PUSH
  } fetch_state_e;

  // In 8x16 mode the row's upper half selects the odd tile of the pair.
  function automatic logic [11:0] pattern_offset(input logic [7:0] tile,
                                                 input logic [3:0] line,
                                                 input logic       obj16,
                                                 input logic       plane);
    logic [7:0] t;
    t = tile;
    if (obj16) t[0] = line[3];
    return {t, line[2:0], plane};
  endfunction

endpackage

// File: rtl/sprite_fetch_arbiter_if.sv
// rtl/sprite_fetch_arbiter_if.sv - sprite store / BG fetcher / VRAM mux bundle
interface sprite_fetch_arbiter_if;
  import sprite_fetch_arbiter_pkg::*;

  logic               line_start;
  logic               line_end;
  logic               spr_en;
  logic               obj_size;
  logic               spr_match;
  logic [3:0]         spr_slot;
  logic [7:0]         spr_tile;
  logic [3:0]         spr_line;
  logic               bg_tile_done;
  logic [7:0]         vram_rdata;
  logic               bg_stall;
  logic               spr_grant;
  logic               vram_rd;
  logic [VRAM_AW-1:0] vram_addr;
  logic [7:0]         spr_lo;
  logic [7:0]         spr_hi;
  logic               spr_valid;
  logic [3:0]         spr_done_slot;
  logic               clear_slot;
  logic [3:0]         spr_count;
  logic [8:0]         stall_cycles;

  modport master (
    input  line_start, line_end, spr_en, obj_size, spr_match, spr_slot, spr_tile,
           spr_line, bg_tile_done, vram_rdata,
    output bg_stall, spr_grant, vram_rd, vram_addr, spr_lo, spr_hi, spr_valid,
           spr_done_slot, clear_slot, spr_count, stall_cycles
  );

  modport slave (
    output line_start, line_end, spr_en, obj_size, spr_match, spr_slot, spr_tile,
           spr_line, bg_tile_done, vram_rdata,
    input  bg_stall, spr_grant, vram_rd, vram_addr, spr_lo, spr_hi, spr_valid,
           spr_done_slot, clear_slot, spr_count, stall_cycles
  );

endinterface

// File: rtl/sprite_fetch_arbiter_spr_pattern_addr.sv
// rtl/sprite_fetch_arbiter_spr_pattern_addr.sv - tile/row/plane to 13-bit pattern address
module spr_pattern_addr
  import sprite_fetch_arbiter_pkg::*;
#(
  parameter logic [VRAM_AW-1:0] TILE_BASE = SPR_TILE_BASE
) (
  input  logic [7:0]         tile_i,
  input  logic [3:0]         line_i,
  input  logic               obj16_i,
  input  logic               plane_i,
  output logic [VRAM_AW-1:0] addr_o
);

  assign addr_o = TILE_BASE + {1'b0, pattern_offset(tile_i, line_i, obj16_i, plane_i)};

endmodule

// File: rtl/sprite_fetch_arbiter.sv
// rtl/sprite_fetch_arbiter.sv - mode-3 VRAM scheduler between BG tile fetcher and sprite fetcher
module sprite_fetch_arbiter
  import sprite_fetch_arbiter_pkg::*;
#(
  parameter int                 READ_CYCLES = DEF_READ_CYCLES,
  parameter int                 MAX_SPRITES = MAX_SPRITES_PER_LINE,
  parameter logic [VRAM_AW-1:0] TILE_BASE   = SPR_TILE_BASE
) (
  input logic                    clk,
  input logic                    nreset_video,
  sprite_fetch_arbiter_if.master bus
);

  localparam logic [1:0] RD_LAST   = 2'(READ_CYCLES - 1);
  localparam logic [3:0] MAX_CNT   = 4'(MAX_SPRITES);
  localparam logic [8:0] STALL_MAX = 9'h1FF;

  fetch_state_e       state_q, state_d;
  logic [1:0]         rd_cnt_q, rd_cnt_d;
  logic [3:0]         slot_q, slot_d;
  logic [7:0]         tile_q, tile_d;
  logic [3:0]         line_q, line_d;
  logic               obj16_q, obj16_d;
  logic [7:0]         lo_q, lo_d;
  logic [7:0]         hi_q, hi_d;
  logic [3:0]         done_slot_q, done_slot_d;
  logic [3:0]         count_q, count_d;
  logic [8:0]         stall_q, stall_d;

  logic               reading;
  logic               rd_last;
  logic               in_push;
  logic               push_fire;
  logic               match_ok;
  logic               capture;
  logic [3:0]         count_eff;
  logic [VRAM_AW-1:0] pat_addr;

  assign reading   = (state_q == LO_RD) || (state_q == HI_RD);
  assign rd_last   = (rd_cnt_q == RD_LAST);
  assign in_push   = (state_q == PUSH);
  assign push_fire = in_push && !bus.line_end;
  assign count_eff = in_push ? count_q + 4'd1 : count_q;
  // The store keeps the just-fetched sprite matched until clear_slot lands,
  // so in PUSH that same slot must not be fetched a second time.
  assign match_ok  = bus.spr_match && bus.spr_en && (count_eff < MAX_CNT) &&
                     !(in_push && (bus.spr_slot == slot_q));

  spr_pattern_addr #(.TILE_BASE(TILE_BASE)) u_pattern_addr (
    .tile_i  (tile_q),
    .line_i  (line_q),
    .obj16_i (obj16_q),
    .plane_i (state_q == HI_RD),
    .addr_o  (pat_addr)
  );

  always_comb begin
    state_d     = state_q;
    rd_cnt_d    = rd_cnt_q;
    slot_d      = slot_q;
    tile_d      = tile_q;
    line_d      = line_q;
    obj16_d     = obj16_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    done_slot_d = done_slot_q;
    count_d     = count_q;
    stall_d     = stall_q;
    capture     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (match_ok) begin
          state_d = WAIT_BG;
          capture = 1'b1;
        end
      end
      WAIT_BG: begin
        if (bus.bg_tile_done) begin
          state_d  = LO_RD;
          rd_cnt_d = '0;
        end
      end
      LO_RD: begin
        if (rd_last) begin
          lo_d     = bus.vram_rdata;
          state_d  = HI_RD;
          rd_cnt_d = '0;
        end else begin
          rd_cnt_d = rd_cnt_q + 2'd1;
        end
      end
      HI_RD: begin
        if (rd_last) begin
          hi_d        = bus.vram_rdata;
          done_slot_d = slot_q;
          state_d     = PUSH;
          rd_cnt_d    = '0;
        end else begin
          rd_cnt_d = rd_cnt_q + 2'd1;
        end
      end
      PUSH: begin
        // The BG tile is already in the FIFO, so a chained sprite skips WAIT_BG.
        if (match_ok) begin
          state_d  = LO_RD;
          rd_cnt_d = '0;
          capture  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (capture) begin
      slot_d  = bus.spr_slot;
      tile_d  = bus.spr_tile;
      line_d  = bus.spr_line;
      obj16_d = bus.obj_size;
    end

    if (bus.line_end) begin
      state_d     = IDLE;
      rd_cnt_d    = '0;
      lo_d        = lo_q;
      hi_d        = hi_q;
      done_slot_d = done_slot_q;
    end

    if (push_fire && (count_q < MAX_CNT)) count_d = count_q + 4'd1;
    if ((state_q != IDLE) && (stall_q != STALL_MAX)) stall_d = stall_q + 9'd1;

    if (bus.line_start) begin
      count_d = '0;
      stall_d = '0;
    end
  end

  always_ff @(posedge clk or negedge nreset_video) begin
    if (!nreset_video) begin
      state_q     <= IDLE;
      rd_cnt_q    <= '0;
      slot_q      <= '0;
      tile_q      <= '0;
      line_q      <= '0;
      obj16_q     <= 1'b0;
      lo_q        <= '0;
      hi_q        <= '0;
      done_slot_q <= '0;
      count_q     <= '0;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      rd_cnt_q    <= rd_cnt_d;
      slot_q      <= slot_d;
      tile_q      <= tile_d;
      line_q      <= line_d;
      obj16_q     <= obj16_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      done_slot_q <= done_slot_d;
      count_q     <= count_d;
      stall_q     <= stall_d;
    end
  end

  assign bus.bg_stall      = (state_q != IDLE);
  assign bus.spr_grant     = reading;
  assign bus.vram_rd       = reading;
  assign bus.vram_addr     = reading ? pat_addr : '0;
  assign bus.spr_lo        = lo_q;
  assign bus.spr_hi        = hi_q;
  assign bus.spr_valid     = push_fire;
  assign bus.clear_slot    = push_fire;
  assign bus.spr_done_slot = done_slot_q;
  assign bus.spr_count     = count_q;
  assign bus.stall_cycles  = stall_q;

endmodule

// File: tb/tb_sprite_fetch_arbiter.sv
// tb/tb_sprite_fetch_arbiter.sv - directed bench for sprite_fetch_arbiter
module tb_sprite_fetch_arbiter;

  typedef struct {
    logic [3:0] slot;
    logic [7:0] tile;
    logic [3:0] line;
  } match_t;

  logic clk;
  logic nreset_video;

  sprite_fetch_arbiter_if bus ();

  sprite_fetch_arbiter dut (
    .clk          (clk),
    .nreset_video (nreset_video),
    .bus          (bus)
  );

  // VRAM model: each byte is its address low byte XOR 0x5A.
  assign bus.vram_rdata = bus.vram_addr[7:0] ^ 8'h5A;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks;
  int          n_fail;
  int          cyc;
  int          stall_seen;
  int          valid_cnt;
  int          clear_cnt;
  int          first_valid_at;
  int          last_valid_at;
  int          n_addr;
  logic [12:0] addr_tr [64];
  logic [7:0]  last_lo;
  logic [7:0]  last_hi;
  logic [3:0]  last_slot;
  match_t      feed [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic present_next();
    match_t m;
    if (feed.size() > 0) begin
      m = feed.pop_front();
      bus.spr_match = 1'b1;
      bus.spr_slot  = m.slot;
      bus.spr_tile  = m.tile;
      bus.spr_line  = m.line;
    end else begin
      bus.spr_match = 1'b0;
    end
  endtask

  task automatic clear_trace();
    cyc = 0; stall_seen = 0; valid_cnt = 0; clear_cnt = 0; n_addr = 0;
    first_valid_at = -1; last_valid_at = -1;
    for (int i = 0; i < 64; i++) addr_tr[i] = '0;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    cyc++;
    if (bus.bg_stall) stall_seen++;
    if (bus.vram_rd && n_addr < 64) begin
      addr_tr[n_addr] = bus.vram_addr;
      n_addr++;
    end
    if (bus.spr_valid) begin
      valid_cnt++;
      if (first_valid_at < 0) first_valid_at = cyc;
      last_valid_at = cyc;
      last_lo   = bus.spr_lo;
      last_hi   = bus.spr_hi;
      last_slot = bus.spr_done_slot;
    end
    if (bus.clear_slot) begin
      clear_cnt++;
      present_next();
    end
  endtask

  task automatic pulse_line_start();
    bus.line_start = 1'b1;
    cycle();
    bus.line_start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0; n_fail = 0;
    bus.line_start = 0; bus.line_end = 0; bus.spr_en = 0; bus.obj_size = 0;
    bus.spr_match = 0; bus.spr_slot = 0; bus.spr_tile = 0; bus.spr_line = 0;
    bus.bg_tile_done = 0;
    nreset_video = 1'b0;
    clear_trace();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_bg_stall", 32'(bus.bg_stall), 0);
    check_eq("rst_vram_addr", 32'(bus.vram_addr), 0);
    check_eq("rst_spr_valid", 32'(bus.spr_valid), 0);
    check_eq("rst_spr_count", 32'(bus.spr_count), 0);
    check_eq("rst_stall_cycles", 32'(bus.stall_cycles), 0);
    nreset_video = 1'b1;
    bus.spr_en = 1'b1;
    bus.bg_tile_done = 1'b1;
    pulse_line_start();

    // Single 8x8 fetch: {0x42, 3'd5, plane} -> 0x42A / 0x42B.
    clear_trace();
    feed.push_back('{4'd3, 8'h42, 4'd5});
    present_next();
    repeat (8) cycle();
    check_eq("t1_stall_seen", 32'(stall_seen), 6);
    check_eq("t1_valid_cnt", 32'(valid_cnt), 1);
    check_eq("t1_valid_at", 32'(first_valid_at), 6);
    check_eq("t1_clear_cnt", 32'(clear_cnt), 1);
    check_eq("t1_n_addr", 32'(n_addr), 4);
    check_eq("t1_addr_lo", 32'(addr_tr[0]), 32'h42A);
    check_eq("t1_addr_hi", 32'(addr_tr[3]), 32'h42B);
    check_eq("t1_spr_lo", 32'(last_lo), 32'h70);
    check_eq("t1_spr_hi", 32'(last_hi), 32'h71);
    check_eq("t1_done_slot", 32'(last_slot), 3);
    check_eq("t1_spr_count", 32'(bus.spr_count), 1);
    check_eq("t1_stall_cycles", 32'(bus.stall_cycles), 6);
    check_eq("t1_bg_stall_end", 32'(bus.bg_stall), 0);

    // 8x16, line 13: line[3]=1 forces tile bit0 -> tile 0x43, row 5.
    bus.obj_size = 1'b1;
    clear_trace();
    feed.push_back('{4'd4, 8'h42, 4'd13});
    present_next();
    repeat (8) cycle();
    check_eq("t2_addr_lo", 32'(addr_tr[0]), 32'h43A);
    check_eq("t2_addr_hi", 32'(addr_tr[2]), 32'h43B);
    check_eq("t2_spr_lo", 32'(last_lo), 32'h60);
    check_eq("t2_spr_count", 32'(bus.spr_count), 2);

    // 8x16, line 5: line[3]=0 forces tile bit0 low -> tile 0x42.
    clear_trace();
    feed.push_back('{4'd5, 8'h43, 4'd5});
    present_next();
    repeat (8) cycle();
    check_eq("t2b_addr_lo", 32'(addr_tr[0]), 32'h42A);
    check_eq("t2b_spr_count", 32'(bus.spr_count), 3);
    bus.obj_size = 1'b0;

    // Back-to-back: second sprite offered during PUSH.
    pulse_line_start();
    check_eq("t3_count_cleared", 32'(bus.spr_count), 0);
    check_eq("t3_stall_cleared", 32'(bus.stall_cycles), 0);
    clear_trace();
    feed.push_back('{4'd1, 8'h10, 4'd0});
    feed.push_back('{4'd2, 8'h11, 4'd7});
    present_next();
    repeat (14) cycle();
    check_eq("t3_stall_seen", 32'(stall_seen), 11);
    check_eq("t3_valid_cnt", 32'(valid_cnt), 2);
    check_eq("t3_second_valid_at", 32'(last_valid_at), 11);
    check_eq("t3_addr_first", 32'(addr_tr[0]), 32'h100);
    check_eq("t3_addr_second", 32'(addr_tr[4]), 32'h11E);
    check_eq("t3_done_slot", 32'(last_slot), 2);
    check_eq("t3_spr_count", 32'(bus.spr_count), 2);
    check_eq("t3_stall_cycles", 32'(bus.stall_cycles), 11);

    // Cap: 11 sprites offered, only 10 fetched.
    pulse_line_start();
    clear_trace();
    for (int i = 0; i < 11; i++) feed.push_back('{4'(i % 10), 8'(8'h20 + i), 4'd0});
    present_next();
    repeat (70) cycle();
    check_eq("t4_valid_cnt", 32'(valid_cnt), 10);
    check_eq("t4_spr_count", 32'(bus.spr_count), 10);
    check_eq("t4_stall_cycles", 32'(bus.stall_cycles), 51);
    check_eq("t4_bg_stall_low", 32'(bus.bg_stall), 0);
    check_eq("t4_last_slot", 32'(last_slot), 9);
    check_eq("t4_last_hi", 32'(last_hi), 32'hCB);
    bus.spr_match = 1'b0;
    feed.delete();

    // line_start wins over a coincident line_end.
    bus.line_start = 1'b1;
    bus.line_end   = 1'b1;
    cycle();
    bus.line_start = 1'b0;
    bus.line_end   = 1'b0;
    check_eq("t45_count_cleared", 32'(bus.spr_count), 0);
    check_eq("t45_stall_cleared", 32'(bus.stall_cycles), 0);

    // Abort with line_end during the first HI_RD cycle.
    clear_trace();
    feed.push_back('{4'd6, 8'h20, 4'd2});
    present_next();
    repeat (4) cycle();
    check_eq("t5_hi_addr", 32'(bus.vram_addr), 32'h205);
    bus.line_end  = 1'b1;
    bus.spr_match = 1'b0;
    cycle();
    bus.line_end = 1'b0;
    check_eq("t5_bg_stall", 32'(bus.bg_stall), 0);
    check_eq("t5_spr_grant", 32'(bus.spr_grant), 0);
    check_eq("t5_vram_rd", 32'(bus.vram_rd), 0);
    check_eq("t5_valid_cnt", 32'(valid_cnt), 0);
    check_eq("t5_spr_hi_held", 32'(bus.spr_hi), 32'hCB);
    check_eq("t5_spr_count", 32'(bus.spr_count), 0);
    check_eq("t5_stall_cycles", 32'(bus.stall_cycles), 4);
    repeat (3) cycle();
    check_eq("t5_stays_idle", 32'(bus.bg_stall), 0);

    // Sprites disabled: a match must not stall.
    clear_trace();
    bus.spr_en    = 1'b0;
    bus.spr_match = 1'b1;
    bus.spr_slot  = 4'd7;
    repeat (3) cycle();
    check_eq("t_en_no_stall", 32'(stall_seen), 0);
    bus.spr_match = 1'b0;
    bus.spr_en    = 1'b1;

    // Async reset in the middle of LO_RD.
    clear_trace();
    feed.push_back('{4'd8, 8'h55, 4'd1});
    present_next();
    repeat (2) cycle();
    check_eq("t6_in_lo_rd", 32'(bus.spr_grant), 1);
    nreset_video = 1'b0;
    #1;
    check_eq("t6_bg_stall", 32'(bus.bg_stall), 0);
    check_eq("t6_vram_rd", 32'(bus.vram_rd), 0);
    check_eq("t6_vram_addr", 32'(bus.vram_addr), 0);
    check_eq("t6_spr_lo", 32'(bus.spr_lo), 0);
    check_eq("t6_spr_hi", 32'(bus.spr_hi), 0);
    check_eq("t6_stall_cycles", 32'(bus.stall_cycles), 0);
    bus.spr_match = 1'b0;
    @(negedge clk);
    nreset_video = 1'b1;
    cycle();
    check_eq("t6_idle_after", 32'(bus.bg_stall), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
